// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel filter pipeline: mode codes,
// gray-weight shifts and saturating arithmetic helpers.
package pixel_pkg;

  localparam logic [3:0] MODE_GRAY   = 4'd0;
  localparam logic [3:0] MODE_BRIGHT = 4'd1;
  localparam logic [3:0] MODE_DARK   = 4'd2;
  localparam logic [3:0] MODE_INV    = 4'd3;
  localparam logic [3:0] MODE_RED    = 4'd4;
  localparam logic [3:0] MODE_GREEN  = 4'd5;
  localparam logic [3:0] MODE_BLUE   = 4'd6;
  localparam logic [3:0] MODE_PASS   = 4'd7;
  localparam logic [3:0] MODE_THRESH = 4'd8;

  localparam int GR_S1 = 2;
  localparam int GR_S2 = 5;
  localparam int GG_S1 = 1;
  localparam int GG_S2 = 4;
  localparam int GB_S1 = 4;
  localparam int GB_S2 = 5;

  // Helpers work on a fixed wide type; callers cast back to channel width.
  localparam int MAXW = 16;
  typedef logic [MAXW-1:0] wide_t;

  function automatic wide_t sat_max(input wide_t x, input wide_t lim);
    return (x > lim) ? lim : x;
  endfunction

  function automatic wide_t sat_sub(input wide_t a, input wide_t b);
    return (a < b) ? '0 : a - b;
  endfunction

endpackage

// File: rtl/pixel_filter_pipe_if.sv
// Pixel stream bundle: input side, output side and mode select.
interface pixel_filter_pipe_if #(
  parameter int PIX_W = 8
);
  logic [3:0]       select;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] R_in;
  logic [PIX_W-1:0] G_in;
  logic [PIX_W-1:0] B_in;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] R_out;
  logic [PIX_W-1:0] G_out;
  logic [PIX_W-1:0] B_out;
  logic             out_eol;
  logic             out_eof;

  modport master (
    output select, in_valid, R_in, G_in, B_in, out_ready,
    input  in_ready, out_valid, R_out, G_out, B_out,
    input  out_eol, out_eof
  );

  modport slave (
    input  select, in_valid, R_in, G_in, B_in, out_ready,
    output in_ready, out_valid, R_out, G_out, B_out,
    output out_eol, out_eof
  );
endinterface

// File: rtl/pix_sat_op.sv
// Single-channel stage-2 operator: picks the saturated or
// selected result for one colour channel from the latched mode.
module pix_sat_op
  import pixel_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int CH        = 0,
  parameter int DARK_STEP = 7,
  parameter int THRESH    = 128
) (
  input  logic [3:0]       mode_i,
  input  logic [PIX_W-1:0] ch_i,
  input  logic [PIX_W:0]   add_i,
  input  logic [PIX_W-1:0] y_i,
  output logic [PIX_W-1:0] res_o
);
  localparam wide_t MAXV = wide_t'((1 << PIX_W) - 1);
  localparam logic [3:0] KEEP = MODE_RED + 4'(CH);

  always_comb begin
    res_o = ch_i;
    unique case (mode_i)
      MODE_GRAY:   res_o = y_i;
      MODE_BRIGHT: res_o = PIX_W'(sat_max(wide_t'(add_i), MAXV));
      MODE_DARK:   res_o = PIX_W'(sat_sub(wide_t'(ch_i),
                                          wide_t'(DARK_STEP)));
      MODE_INV:    res_o = ~ch_i;
      MODE_RED,
      MODE_GREEN,
      MODE_BLUE:   res_o = (mode_i == KEEP) ? ch_i : '0;
      MODE_THRESH: res_o = (wide_t'(y_i) >= wide_t'(THRESH)) ? '1 : '0;
      default:     res_o = ch_i;
    endcase
  end
endmodule

// File: rtl/pixel_filter_pipe.sv
// Two-stage RGB point-operation filter with frame position tracking.
// The mode is captured on the first accepted pixel of each frame.
module pixel_filter_pipe
  import pixel_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int IMG_W       = 256,
  parameter int IMG_H       = 256,
  parameter int BRIGHT_STEP = 60,
  parameter int DARK_STEP   = 7,
  parameter int THRESH      = 128
) (
  input logic                clk,
  input logic                reset_n,
  pixel_filter_pipe_if.slave bus
);
  localparam int AW = PIX_W + 1;
  localparam int YW = PIX_W + 2;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam wide_t MAXV = wide_t'((1 << PIX_W) - 1);

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    logic          vld;
    logic [3:0]    mode;
    logic [YW-1:0] y;
    pix_t          r;
    pix_t          g;
    pix_t          b;
    logic [AW-1:0] ra;
    logic [AW-1:0] ga;
    logic [AW-1:0] ba;
    logic          eol;
    logic          eof;
  } s1_t;

  typedef struct packed {
    logic vld;
    pix_t r;
    pix_t g;
    pix_t b;
    logic eol;
    logic eof;
  } s2_t;

  s1_t           s1_q, s1_d;
  s2_t           s2_q, s2_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [3:0]    mode_q, mode_d;

  logic          en, acc, sof;
  logic          last_col, last_row;
  logic [YW-1:0] y_sum;
  pix_t          y_sat, r_op, g_op, b_op;

  assign en       = !s2_q.vld || bus.out_ready;
  assign acc      = bus.in_valid && en;
  assign sof      = (col_q == '0) && (row_q == '0);
  assign last_col = col_q == CW'(IMG_W - 1);
  assign last_row = row_q == RW'(IMG_H - 1);

  assign y_sum = {2'b00, bus.R_in >> GR_S1} + {2'b00, bus.R_in >> GR_S2}
               + {2'b00, bus.G_in >> GG_S1} + {2'b00, bus.G_in >> GG_S2}
               + {2'b00, bus.B_in >> GB_S1} + {2'b00, bus.B_in >> GB_S2};

  assign y_sat = PIX_W'(sat_max(wide_t'(s1_q.y), MAXV));

  pix_sat_op #(
    .PIX_W(PIX_W), .CH(0), .DARK_STEP(DARK_STEP), .THRESH(THRESH)
  ) u_op_r (
    .mode_i(s1_q.mode), .ch_i(s1_q.r), .add_i(s1_q.ra),
    .y_i(y_sat), .res_o(r_op)
  );

  pix_sat_op #(
    .PIX_W(PIX_W), .CH(1), .DARK_STEP(DARK_STEP), .THRESH(THRESH)
  ) u_op_g (
    .mode_i(s1_q.mode), .ch_i(s1_q.g), .add_i(s1_q.ga),
    .y_i(y_sat), .res_o(g_op)
  );

  pix_sat_op #(
    .PIX_W(PIX_W), .CH(2), .DARK_STEP(DARK_STEP), .THRESH(THRESH)
  ) u_op_b (
    .mode_i(s1_q.mode), .ch_i(s1_q.b), .add_i(s1_q.ba),
    .y_i(y_sat), .res_o(b_op)
  );

  // Data fields only move with a valid pixel so outputs stay 0 after reset.
  always_comb begin
    s1_d   = s1_q;
    s2_d   = s2_q;
    col_d  = col_q;
    row_d  = row_q;
    mode_d = mode_q;
    if (en) begin
      s1_d.vld = bus.in_valid;
      if (bus.in_valid) begin
        s1_d.mode = sof ? bus.select : mode_q;
        s1_d.y    = y_sum;
        s1_d.r    = bus.R_in;
        s1_d.g    = bus.G_in;
        s1_d.b    = bus.B_in;
        s1_d.ra   = {1'b0, bus.R_in} + AW'(BRIGHT_STEP);
        s1_d.ga   = {1'b0, bus.G_in} + AW'(BRIGHT_STEP);
        s1_d.ba   = {1'b0, bus.B_in} + AW'(BRIGHT_STEP);
        s1_d.eol  = last_col;
        s1_d.eof  = last_col && last_row;
      end
      s2_d.vld = s1_q.vld;
      if (s1_q.vld) begin
        s2_d.r   = r_op;
        s2_d.g   = g_op;
        s2_d.b   = b_op;
        s2_d.eol = s1_q.eol;
        s2_d.eof = s1_q.eof;
      end
    end
    if (acc) begin
      if (sof) mode_d = bus.select;
      col_d = last_col ? '0 : col_q + CW'(1);
      if (last_col) row_d = last_row ? '0 : row_q + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= MODE_PASS;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      col_q  <= col_d;
      row_q  <= row_d;
      mode_q <= mode_d;
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = s2_q.vld;
  assign bus.R_out     = s2_q.r;
  assign bus.G_out     = s2_q.g;
  assign bus.B_out     = s2_q.b;
  assign bus.out_eol   = s2_q.eol;
  assign bus.out_eof   = s2_q.eof;
endmodule

// File: tb/tb_pixel_filter_pipe.sv
// Bench for pixel_filter_pipe: directed vectors, frame/stall/reset
// sequences and a randomized stream against an arithmetic model.
module tb_pixel_filter_pipe;
  localparam int PW = 8;
  localparam int IW = 4;
  localparam int IH = 2;
  localparam int BS = 60;
  localparam int DS = 7;
  localparam int TH = 128;
  localparam int MX = (1 << PW) - 1;

  typedef struct {
    logic [3:0] mode;
    logic [7:0] r, g, b;
    logic [7:0] er, eg, eb;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  pixel_filter_pipe_if #(.PIX_W(PW)) bus ();

  pixel_filter_pipe #(
    .PIX_W(PW), .IMG_W(IW), .IMG_H(IH),
    .BRIGHT_STEP(BS), .DARK_STEP(DS), .THRESH(TH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_out = 0;
  int n_eol = 0;
  int n_eof = 0;
  int m_col, m_row, m_mode;
  logic [25:0] q[$];
  logic prev_stall = 1'b0;
  logic [25:0] prev_out;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mdl_reset();
    m_col = 0;
    m_row = 0;
    m_mode = 7;
    q.delete();
    prev_stall = 1'b0;
  endtask

  // Reference: plain integer arithmetic on the mode rules.
  task automatic mdl_accept(input logic [3:0] sel, input logic [23:0] px);
    int ch[3];
    int o[3];
    int y;
    logic eol, eof;
    if (m_col == 0 && m_row == 0) m_mode = int'(sel);
    ch[0] = int'(px[23:16]);
    ch[1] = int'(px[15:8]);
    ch[2] = int'(px[7:0]);
    y = (ch[0] >> 2) + (ch[0] >> 5) + (ch[1] >> 1) + (ch[1] >> 4)
      + (ch[2] >> 4) + (ch[2] >> 5);
    if (y > MX) y = MX;
    for (int i = 0; i < 3; i++) begin
      case (m_mode)
        0: o[i] = y;
        1: o[i] = (ch[i] + BS > MX) ? MX : ch[i] + BS;
        2: o[i] = (ch[i] < DS) ? 0 : ch[i] - DS;
        3: o[i] = MX - ch[i];
        4, 5, 6: o[i] = (m_mode - 4 == i) ? ch[i] : 0;
        8: o[i] = (y >= TH) ? MX : 0;
        default: o[i] = ch[i];
      endcase
    end
    eol = (m_col == IW - 1);
    eof = eol && (m_row == IH - 1);
    q.push_back({8'(o[0]), 8'(o[1]), 8'(o[2]), eol, eof});
    m_col++;
    if (m_col == IW) begin
      m_col = 0;
      m_row++;
      if (m_row == IH) m_row = 0;
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mdl_reset();
    #1;
    chk("reset_state",
        {bus.out_valid, bus.R_out, bus.G_out, bus.B_out,
         bus.out_eol, bus.out_eof, bus.in_ready},
        {1'b0, 24'h0, 2'b00, 1'b1});
  endtask

  // One clock: drive, check handshakes before the edge, then advance.
  task automatic cyc(input logic v, input logic [3:0] sel,
                     input logic [23:0] px, input logic ordy,
                     output logic took);
    logic [25:0] got;
    bus.in_valid = v;
    bus.select = sel;
    bus.R_in = px[23:16];
    bus.G_in = px[15:8];
    bus.B_in = px[7:0];
    bus.out_ready = ordy;
    #1;
    got = {bus.R_out, bus.G_out, bus.B_out, bus.out_eol, bus.out_eof};
    if (bus.out_valid && !ordy) begin
      chk("stall_in_ready", bus.in_ready, 0);
      if (prev_stall) chk("stall_hold", got, prev_out);
      prev_stall = 1'b1;
      prev_out = got;
    end else begin
      prev_stall = 1'b0;
    end
    if (bus.out_valid && ordy) begin
      chk("out_expected", q.size() != 0, 1);
      if (q.size() != 0) chk("out_px", got, q.pop_front());
      n_out++;
      if (got[1]) n_eol++;
      if (got[0]) n_eof++;
    end
    took = v && bus.in_ready;
    if (took) mdl_accept(sel, px);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] sel, input logic [23:0] px);
    logic took = 1'b0;
    for (int k = 0; k < 20 && !took; k++) cyc(1'b1, sel, px, 1'b1, took);
    chk("send_accept", took, 1);
  endtask

  task automatic drain();
    logic took;
    for (int k = 0; k < 6; k++) cyc(1'b0, 4'd0, 24'h0, 1'b1, took);
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic add_vec(input logic [3:0] m, input logic [7:0] r, g, b,
                         input logic [7:0] er, eg, eb);
    vec_t v;
    v.mode = m;
    v.r = r;
    v.g = g;
    v.b = b;
    v.er = er;
    v.eg = eg;
    v.eb = eb;
    tv.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int idx;
    logic took;
    logic [23:0] px;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.select = 4'd0;
    bus.R_in = '0;
    bus.G_in = '0;
    bus.B_in = '0;
    #2;

    add_vec(4'd0, 8'd100, 8'd150, 8'd50, 8'd116, 8'd116, 8'd116);
    add_vec(4'd1, 8'd200, 8'd10, 8'd255, 8'd255, 8'd70, 8'd255);
    add_vec(4'd2, 8'd5, 8'd7, 8'd100, 8'd0, 8'd0, 8'd93);
    add_vec(4'd8, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    add_vec(4'd8, 8'd100, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0);
    add_vec(4'd8, 8'd140, 8'd139, 8'd139, 8'd255, 8'd255, 8'd255);
    add_vec(4'd8, 8'd139, 8'd139, 8'd139, 8'd0, 8'd0, 8'd0);
    add_vec(4'd3, 8'd10, 8'd200, 8'd255, 8'd245, 8'd55, 8'd0);
    add_vec(4'd4, 8'd1, 8'd2, 8'd3, 8'd1, 8'd0, 8'd0);
    add_vec(4'd5, 8'd1, 8'd2, 8'd3, 8'd0, 8'd2, 8'd0);
    add_vec(4'd6, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd3);
    add_vec(4'd7, 8'd9, 8'd8, 8'd7, 8'd9, 8'd8, 8'd7);
    add_vec(4'd12, 8'd9, 8'd8, 8'd7, 8'd9, 8'd8, 8'd7);
    add_vec(4'd1, 8'd195, 8'd196, 8'd0, 8'd255, 8'd255, 8'd60);
    add_vec(4'd2, 8'd7, 8'd8, 8'd6, 8'd0, 8'd1, 8'd0);

    foreach (tv[i]) begin
      do_reset();
      bus.select = tv[i].mode;
      bus.R_in = tv[i].r;
      bus.G_in = tv[i].g;
      bus.B_in = tv[i].b;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      #1;
      chk($sformatf("tv%0d_lat1", i), bus.out_valid, 0);
      @(posedge clk);
      #1;
      chk($sformatf("tv%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("tv%0d_rgb", i), {bus.R_out, bus.G_out, bus.B_out},
          {tv[i].er, tv[i].eg, tv[i].eb});
    end

    // Stall: out_ready low for three cycles mid-stream.
    do_reset();
    n_out = 0;
    idx = 0;
    for (int c = 0; c < 60 && (idx < 10 || q.size() != 0); c++) begin
      px = {8'(idx * 20 + 1), 8'(idx * 7 + 3), 8'(200 - idx)};
      cyc(idx < 10, 4'd1, px, !(c >= 4 && c < 7), took);
      if (took) idx++;
    end
    chk("stall_out_cnt", n_out, 10);
    chk("stall_q_empty", q.size(), 0);

    // Frame: select changes mid-frame are ignored.
    do_reset();
    n_out = 0;
    n_eol = 0;
    n_eof = 0;
    for (int k = 0; k < 8; k++)
      send((k < 2) ? 4'd3 : 4'd4, 24'($urandom));
    drain();
    chk("frame_out_cnt", n_out, 8);
    chk("frame_eol_cnt", n_eol, 2);
    chk("frame_eof_cnt", n_eof, 1);
    n_out = 0;
    send(4'd4, 24'($urandom));
    for (int k = 0; k < 7; k++) send(4'd0, 24'($urandom));
    drain();
    chk("frame2_out_cnt", n_out, 8);

    // Asynchronous reset mid-frame.
    do_reset();
    for (int k = 0; k < 3; k++) send(4'd6, 24'($urandom));
    chk("pre_reset_valid", bus.out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mdl_reset();
    n_out = 0;
    n_eof = 0;
    send(4'd2, 24'($urandom));
    for (int k = 0; k < 7; k++) send(4'd5, 24'($urandom));
    drain();
    chk("rst_out_cnt", n_out, 8);
    chk("rst_eof_cnt", n_eof, 1);

    // Randomized stream with random bubbles and backpressure.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
          24'($urandom), $urandom_range(0, 9) < 7, took);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
